fft_bfly_feed: RTL

FFT_BFLY_FEED -- requirements
Module: fft_bfly_feed

---
 rtl/fft_pkg.sv | 14 +
 rtl/fft_vec_ram.sv | 42 ++++
 rtl/fft_bfly_feed.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/fft_pkg.sv
// Shared defaults and FSM state type for the FFT butterfly feeder.
package fft_pkg;

    localparam int N_DEF      = 16;  // samples per clock
    localparam int IN_BIT_DEF = 9;   // signed sample width
    localparam int DEPTH_DEF  = 16;  // vectors per half-frame

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        PAIR = 2'd2
    } state_t;

endpackage

// File: rtl/fft_vec_ram.sv
// Half-frame vector store: one write port, one registered read port.
// The read register only updates on i_rd_en, so it holds its last vector
// between reads and can drive the first-half outputs directly.
module fft_vec_ram #(
    parameter int DEPTH = 16,
    parameter int W     = 288
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_wr_en,
    input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
    input  logic [W-1:0]             i_wr_data,
    input  logic                     i_rd_en,
    input  logic [$clog2(DEPTH)-1:0] i_rd_addr,
    output logic [W-1:0]             o_rd_data
);

    logic [W-1:0] r_mem [0:DEPTH-1];
    logic [W-1:0] r_rd_data;

    // Storage write.
    // NOTE: the array has no reset on purpose; a full FILL always precedes
    // any read, so stale contents never escape, and a reset here would
    // prevent mapping onto block RAM.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Registered read; only the output register is cleared by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/fft_bfly_feed.sv
// Pairs x[n] with x[n+DEPTH*N] for a radix-2 butterfly stage.
// The first half-frame is stored in fft_vec_ram. During the second half
// each incoming vector is registered alongside the stored vector of the
// same index, so a pair appears one cycle after its second-half vector.
module fft_bfly_feed
    import fft_pkg::*;
#(
    parameter int N      = N_DEF,
    parameter int IN_BIT = IN_BIT_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     valid_in,
    input  logic signed [IN_BIT-1:0] din_i   [0:N-1],
    input  logic signed [IN_BIT-1:0] din_q   [0:N-1],
    output logic                     flag_out,
    output logic signed [IN_BIT-1:0] dout1_i [0:N-1],
    output logic signed [IN_BIT-1:0] dout1_q [0:N-1],
    output logic signed [IN_BIT-1:0] dout2_i [0:N-1],
    output logic signed [IN_BIT-1:0] dout2_q [0:N-1],
    output logic [$clog2(DEPTH)-1:0] pair_idx,
    output logic                     frame_last
);

    localparam int            CW       = $clog2(DEPTH);
    localparam int            VW       = 2 * N * IN_BIT;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEPTH - 1);

    state_t                  r_state, w_state_nxt;
    logic [CW-1:0]           r_cnt, w_cnt_nxt;
    logic                    w_wr_en;
    logic                    w_pair;
    logic                    w_last;
    logic [VW-1:0]           w_wr_data;
    logic [VW-1:0]           w_rd_data;
    logic                    r_flag;
    logic                    r_last;
    logic [CW-1:0]           r_idx;
    logic signed [IN_BIT-1:0] r_dout2_i [0:N-1];
    logic signed [IN_BIT-1:0] r_dout2_q [0:N-1];

    // State and counter register.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next state, counter and strobes; buffer writes only in IDLE/FILL.
    // NOTE: every signal gets a default first so no path infers a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_wr_en     = 1'b0;
        w_pair      = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            IDLE: begin
                if (valid_in) begin
                    w_wr_en     = 1'b1;            // r_cnt is 0 in IDLE
                    w_cnt_nxt   = CW'(1);
                    w_state_nxt = FILL;
                end
            end
            FILL: begin
                if (valid_in) begin
                    w_wr_en = 1'b1;
                    if (r_cnt == CNT_LAST) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = PAIR;
                    end else begin
                        w_cnt_nxt = r_cnt + CW'(1);
                    end
                end
            end
            PAIR: begin
                if (valid_in) begin
                    w_pair = 1'b1;
                    if (r_cnt == CNT_LAST) begin
                        w_last      = 1'b1;
                        w_cnt_nxt   = '0;
                        w_state_nxt = IDLE;
                    end else begin
                        w_cnt_nxt = r_cnt + CW'(1);
                    end
                end
            end
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Flatten the incoming vector for storage: I lanes low, Q lanes high.
    always_comb begin
        w_wr_data = '0;
        for (int j = 0; j < N; j++) begin
            w_wr_data[j*IN_BIT +: IN_BIT]     = din_i[j];
            w_wr_data[(N+j)*IN_BIT +: IN_BIT] = din_q[j];
        end
    end

    fft_vec_ram #(
        .DEPTH (DEPTH),
        .W     (VW)
    ) u_ram (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (r_cnt),
        .i_wr_data (w_wr_data),
        .i_rd_en   (w_pair),
        .i_rd_addr (r_cnt),
        .o_rd_data (w_rd_data)
    );

    // Pair output registers; data and index hold between pairs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_flag <= 1'b0;
            r_last <= 1'b0;
            r_idx  <= '0;
            for (int j = 0; j < N; j++) begin
                r_dout2_i[j] <= '0;
                r_dout2_q[j] <= '0;
            end
        end else begin
            r_flag <= w_pair;
            r_last <= w_last;
            if (w_pair) begin
                r_idx     <= r_cnt;
                r_dout2_i <= din_i;
                r_dout2_q <= din_q;
            end
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_lane
        assign dout1_i[g] = w_rd_data[g*IN_BIT +: IN_BIT];
        assign dout1_q[g] = w_rd_data[(N+g)*IN_BIT +: IN_BIT];
    end

    assign dout2_i    = r_dout2_i;
    assign dout2_q    = r_dout2_q;
    assign flag_out   = r_flag;
    assign frame_last = r_last;
    assign pair_idx   = r_idx;

endmodule
